pnr_histogram: RTL and testbench

PNR_HISTOGRAM -- requirements
Module: pnr_histogram

---
 rtl/pnr_pkg.sv | 14 +
 rtl/pnr_histogram_if.sv | 19 +
 rtl/pnr_sat_counter.sv | 24 ++
 rtl/pnr_histogram.sv | 136 +++++++++++++
 tb/tb_pnr_histogram.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pnr_pkg.sv
// Shared types and read-map constants for the photon-number histogram.
package pnr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [3:0] ADDR_TOTAL   = 4'd8;
    localparam logic [3:0] ADDR_INVALID = 4'd9;

endpackage

// File: rtl/pnr_histogram_if.sv
// Register-read bus between a host and the histogram.
interface pnr_histogram_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       rd_addr_i;
    logic             rd_req_i;
    logic [CNT_W-1:0] rd_data_o;
    logic             rd_ack_o;

    modport master (
        output rd_addr_i, rd_req_i,
        input  rd_data_o, rd_ack_o
    );

    modport slave (
        input  rd_addr_i, rd_req_i,
        output rd_data_o, rd_ack_o
    );
endinterface

// File: rtl/pnr_sat_counter.sv
// Saturating up-counter with synchronous clear.
module pnr_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pnr_histogram.sv
// Photon-number histogram: per-bin, total and invalid event counters.
module pnr_histogram
    import pnr_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int NBINS = 8
) (
    input  logic              ADC_CLK,
    input  logic              rstn_i,
    input  logic [NBINS-1:0]  pnr_onehot_i,
    input  logic              hist_start_i,
    input  logic              hist_clear_i,
    input  logic [CNT_W-1:0]  hist_target_i,
    pnr_histogram_if.slave    rd,
    output logic              hist_busy_o,
    output logic              hist_done_o
);
    state_e           state_q;
    logic             or_q;
    logic [CNT_W-1:0] target_q;
    logic             busy_q;
    logic             done_q;
    logic             ack_q;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] rd_mux_d;

    logic [CNT_W-1:0] bin_cnt [NBINS];
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] inval_cnt;

    logic evt;
    logic onehot;
    logic inc_ok;
    logic inc_bad;
    logic hit;

    assign evt     = (|pnr_onehot_i) & ~or_q & (state_q == ST_RUN);
    assign onehot  = ((pnr_onehot_i & (pnr_onehot_i - NBINS'(1))) == '0);
    assign inc_ok  = evt & onehot;
    assign inc_bad = evt & ~onehot;

    // Only a valid event that actually moves the total can reach the target.
    assign hit = inc_ok && (target_q != '0) && (total_cnt != '1)
              && ((total_cnt + CNT_W'(1)) == target_q);

    for (genvar k = 0; k < NBINS; k++) begin : g_bin
        pnr_sat_counter #(.CNT_W(CNT_W)) u_bin (
            .clk_i  (ADC_CLK),
            .rstn_i (rstn_i),
            .clr_i  (hist_clear_i),
            .inc_i  (inc_ok & pnr_onehot_i[k]),
            .cnt_o  (bin_cnt[k])
        );
    end

    pnr_sat_counter #(.CNT_W(CNT_W)) u_total (
        .clk_i  (ADC_CLK),
        .rstn_i (rstn_i),
        .clr_i  (hist_clear_i),
        .inc_i  (inc_ok),
        .cnt_o  (total_cnt)
    );

    pnr_sat_counter #(.CNT_W(CNT_W)) u_inval (
        .clk_i  (ADC_CLK),
        .rstn_i (rstn_i),
        .clr_i  (hist_clear_i),
        .inc_i  (inc_bad),
        .cnt_o  (inval_cnt)
    );

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (hist_clear_i) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (hist_start_i) begin
                        state_q  <= ST_RUN;
                        target_q <= hist_target_i;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                ST_RUN: begin
                    if (hit) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux_d = '0;
        if (rd.rd_addr_i == ADDR_TOTAL) begin
            rd_mux_d = total_cnt;
        end else if (rd.rd_addr_i == ADDR_INVALID) begin
            rd_mux_d = inval_cnt;
        end else begin
            for (int k = 0; k < NBINS; k++) begin
                if (rd.rd_addr_i == 4'(k)) rd_mux_d = bin_cnt[k];
            end
        end
    end

    always_ff @(posedge ADC_CLK or negedge rstn_i) begin
        if (!rstn_i) begin
            or_q   <= 1'b0;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            or_q  <= |pnr_onehot_i;
            ack_q <= rd.rd_req_i;
            if (rd.rd_req_i) data_q <= rd_mux_d;
        end
    end

    assign rd.rd_ack_o  = ack_q;
    assign rd.rd_data_o = data_q;
    assign hist_busy_o  = busy_q;
    assign hist_done_o  = done_q;
endmodule

// File: tb/tb_pnr_histogram.sv
// Scoreboard bench for pnr_histogram: a 32-bit and a 4-bit instance.
module tb_pnr_histogram;
    import pnr_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  onehot;
    logic        start;
    logic        clear;
    logic        start2;
    logic [31:0] target;
    logic [3:0]  tgt2;
    logic        busy, done, busy2, done2;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pnr_histogram_if #(.CNT_W(32)) bus ();
    pnr_histogram_if #(.CNT_W(4))  bus2 ();

    pnr_histogram #(.CNT_W(32), .NBINS(8)) dut (
        .ADC_CLK       (clk),
        .rstn_i        (rstn),
        .pnr_onehot_i  (onehot),
        .hist_start_i  (start),
        .hist_clear_i  (clear),
        .hist_target_i (target),
        .rd            (bus),
        .hist_busy_o   (busy),
        .hist_done_o   (done)
    );

    pnr_histogram #(.CNT_W(4), .NBINS(8)) dut4 (
        .ADC_CLK       (clk),
        .rstn_i        (rstn),
        .pnr_onehot_i  (onehot),
        .hist_start_i  (start2),
        .hist_clear_i  (clear),
        .hist_target_i (tgt2),
        .rd            (bus2),
        .hist_busy_o   (busy2),
        .hist_done_o   (done2)
    );

    task automatic rd(input bit sel, input logic [3:0] a,
                      output logic [31:0] d, output logic ack);
        @(negedge clk);
        if (sel) begin
            bus2.rd_addr_i = a;
            bus2.rd_req_i  = 1'b1;
        end else begin
            bus.rd_addr_i = a;
            bus.rd_req_i  = 1'b1;
        end
        @(negedge clk);
        bus.rd_req_i  = 1'b0;
        bus2.rd_req_i = 1'b0;
        d   = sel ? {28'd0, bus2.rd_data_o} : bus.rd_data_o;
        ack = sel ? bus2.rd_ack_o : bus.rd_ack_o;
    endtask

    task automatic pulse(input logic [7:0] v, input int n);
        repeat (n) begin
            @(negedge clk) onehot = v;
            @(negedge clk);
            @(negedge clk) onehot = 8'h00;
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic        ack;
        rstn = 1'b0; onehot = '0; start = 0; clear = 0; start2 = 0;
        target = '0; tgt2 = '0;
        bus.rd_addr_i = '0;  bus.rd_req_i = 1'b0;
        bus2.rd_addr_i = '0; bus2.rd_req_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, bus.rd_ack_o} !== 3'b000 || bus.rd_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_outs: busy=%b done=%b ack=%b data=%0d, want 0 0 0 0",
                     busy, done, bus.rd_ack_o, bus.rd_data_o);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(32'd0);
            rd(0, 4'(i), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL reset_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         i, ack, d, e);
            end
        end
    endtask

    task automatic test_onehot();
        int ta [4] = '{2, 0, 8, 7};
        int te [4] = '{2, 1, 3, 0};
        logic [31:0] d, e;
        logic        ack;
        target = 32'd3;
        do_start();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL onehot_busy: got %b, want 1", busy);
        end
        pulse(8'h04, 1);
        pulse(8'h01, 1);
        pulse(8'h04, 1);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL onehot_done: done=%b busy=%b, want 1 0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(te[i]));
            rd(0, 4'(ta[i]), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL onehot_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         ta[i], ack, d, e);
            end
        end
    endtask

    task automatic test_invalid();
        int ta [5] = '{9, 8, 1, 2, 0};
        int te [5] = '{1, 1, 0, 0, 1};
        logic [31:0] d, e;
        logic        ack;
        do_clear();
        target = 32'd0;
        do_start();
        pulse(8'h06, 1);
        @(negedge clk) onehot = 8'h01;
        repeat (4) @(negedge clk);
        onehot = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'(te[i]));
            rd(0, 4'(ta[i]), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL invalid_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         ta[i], ack, d, e);
            end
        end
    endtask

    task automatic test_target();
        int ta [6] = '{8, 7, 8, 8, 7, 0};
        int te [6] = '{4, 4, 6, 5, 5, 0};
        logic [31:0] d, e;
        logic        ack;
        do_clear();
        target = 32'd4;
        do_start();
        target = 32'd0;
        pulse(8'h80, 5);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL target4_done: done=%b busy=%b, want 1 0", done, busy);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'(te[i]));
            rd(0, 4'(ta[i]), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL target4_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         ta[i], ack, d, e);
            end
        end
        target = 32'd6;
        do_start();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL restart_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        pulse(8'h80, 3);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL target6_done: got %b, want 1", done);
        end
        exp_q.push_back(32'(te[2]));
        rd(0, 4'(ta[2]), d, ack);
        e = exp_q.pop_front();
        n_cmp++;
        if (ack !== 1'b1 || d !== e) begin
            n_err++;
            $display("FAIL target6_rd: ack=%b data=%0d, want ack=1 data=%0d", ack, d, e);
        end
        do_clear();
        target = 32'd0;
        do_start();
        pulse(8'h80, 5);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL target0_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        for (int i = 3; i < 6; i++) begin
            exp_q.push_back(32'(te[i]));
            rd(0, 4'(ta[i]), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL target0_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         ta[i], ack, d, e);
            end
        end
    endtask

    task automatic test_clear_start();
        logic [31:0] d, e;
        logic        ack;
        @(negedge clk) begin clear = 1'b1; start = 1'b1; end
        @(negedge clk) clear = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clr_start_state: busy=%b done=%b, want 0 0", busy, done);
        end
        @(negedge clk) start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_clear: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(32'd0);
            rd(0, 4'(i), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL cleared_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         i, ack, d, e);
            end
        end
        do_start();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL idle_start: busy=%b, want 1", busy);
        end
        do_clear();
    endtask

    task automatic test_saturate();
        int ta [3] = '{1, 8, 9};
        int te [3] = '{15, 15, 0};
        logic [31:0] d, e;
        logic        ack;
        tgt2 = 4'd0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        pulse(8'h02, 20);
        n_cmp++;
        if (busy2 !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL sat_busy: busy4=%b busy32=%b, want 1 0", busy2, busy);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(te[i]));
            rd(1, 4'(ta[i]), d, ack);
            e = exp_q.pop_front();
            n_cmp++;
            if (ack !== 1'b1 || d !== e) begin
                n_err++;
                $display("FAIL sat_rd a=%0d: ack=%b data=%0d, want ack=1 data=%0d",
                         ta[i], ack, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        target = 32'd0;
        do_start();
        pulse(8'h04, 2);
        @(negedge clk) begin bus.rd_addr_i = 4'd2; bus.rd_req_i = 1'b1; end
        exp_q.push_back(32'd2);
        @(negedge clk) bus.rd_addr_i = 4'd12;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.rd_ack_o !== 1'b1 || bus.rd_data_o !== e) begin
            n_err++;
            $display("FAIL b2b_bin2: ack=%b data=%0d, want ack=1 data=%0d",
                     bus.rd_ack_o, bus.rd_data_o, e);
        end
        @(negedge clk) bus.rd_req_i = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.rd_ack_o !== 1'b1 || bus.rd_data_o !== e) begin
            n_err++;
            $display("FAIL b2b_unused: ack=%b data=%0d, want ack=1 data=%0d",
                     bus.rd_ack_o, bus.rd_data_o, e);
        end
        @(negedge clk) bus.rd_addr_i = 4'd2;
        n_cmp++;
        if (bus.rd_ack_o !== 1'b0 || bus.rd_data_o !== 32'd0) begin
            n_err++;
            $display("FAIL b2b_hold: ack=%b data=%0d, want ack=0 data=0",
                     bus.rd_ack_o, bus.rd_data_o);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rd_ack_o !== 1'b0 || bus.rd_data_o !== 32'd0) begin
            n_err++;
            $display("FAIL b2b_hold2: ack=%b data=%0d, want ack=0 data=0",
                     bus.rd_ack_o, bus.rd_data_o);
        end
    endtask

    task automatic test_reset_run();
        logic [31:0] d, e;
        logic        ack;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_busy: busy=%b, want 1", busy);
        end
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_run: busy=%b done=%b busy4=%b, want 0 0 0",
                     busy, done, busy2);
        end
        pulse(8'h04, 1);
        exp_q.push_back(32'd0);
        rd(0, ADDR_TOTAL, d, ack);
        e = exp_q.pop_front();
        n_cmp++;
        if (ack !== 1'b1 || d !== e) begin
            n_err++;
            $display("FAIL reset_run_total: ack=%b data=%0d, want ack=1 data=%0d",
                     ack, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_invalid();
        test_target();
        test_clear_start();
        test_saturate();
        test_back_to_back();
        test_reset_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
